// File: rtl/fp32_to_bfp_grouper.sv
// fp32_to_bfp_grouper: collects GRPSIZE FP32 elements and emits them as one
// block-floating-point group (shared max exponent, truncated aligned mantissas).
module fp32_to_bfp_grouper #(
   parameter int GRPSIZE    = 16,
   parameter int BFPEXPSIZE = 8,
   parameter int BFPMANSIZE = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_valid,
   input  logic [31:0]           i_fp,
   output logic                  o_ready,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [BFPEXPSIZE-1:0] o_E,
   output logic [BFPMANSIZE-1:0] o_M [0:GRPSIZE-1],
   output logic                  o_special
);
   localparam int CW = $clog2(GRPSIZE);
   localparam int MW = BFPMANSIZE - 1;
   localparam int FW = BFPMANSIZE - 2;
   localparam int SW = 9 + FW;
   typedef enum logic [1:0] {COLLECT, ALIGN, OUT} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [7:0] max_e;
   logic [SW-1:0] grp [0:GRPSIZE-1];
   logic [BFPMANSIZE-1:0] m_next [0:GRPSIZE-1];
   logic [GRPSIZE-1:0] spec;
   logic accept;
   logic [7:0] in_e;
   assign o_ready = state == COLLECT;
   assign accept = i_valid && o_ready;
   assign in_e = i_fp[30:23];
   // only sign, exponent and the fraction bits that survive truncation are kept
   for (genvar g = 0; g < GRPSIZE; g++) begin : g_align
      logic [7:0] e;
      logic [7:0] sh;
      logic [MW-1:0] mag;
      assign e = grp[g][SW-2 -: 8];
      assign sh = max_e - e;
      assign mag = &e ? '1 : (e == 8'd0 || sh >= 8'(MW)) ? '0 : {1'b1, grp[g][FW-1:0]} >> sh;
      assign m_next[g] = {grp[g][SW-1] && mag != '0, mag};
      assign spec[g] = &e;
   end
   always_ff @(posedge i_clk)
      if (accept) grp[cnt] <= {i_fp[31:23], i_fp[22 -: FW]};
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= COLLECT;
         cnt       <= '0;
         max_e     <= '0;
         o_valid   <= 1'b0;
         o_E       <= '0;
         o_special <= 1'b0;
         for (int i = 0; i < GRPSIZE; i++) o_M[i] <= '0;
      end else begin
         case (state)
            COLLECT: if (accept) begin
               cnt   <= cnt + 1'b1;
               max_e <= in_e > max_e ? in_e : max_e;
               if (cnt == CW'(GRPSIZE - 1)) state <= ALIGN;
            end
            ALIGN: begin
               o_E       <= BFPEXPSIZE'(max_e);
               o_M       <= m_next;
               o_special <= |spec;
               o_valid   <= 1'b1;
               max_e     <= '0;
               state     <= OUT;
            end
            OUT: if (i_ready) begin
               o_valid <= 1'b0;
               state   <= COLLECT;
            end
            default: state <= COLLECT;
         endcase
      end
   end
endmodule
